// File: rtl/game_frame_sequencer.sv
// game_frame_sequencer
// Top-level screen controller for the two-player tank game. It tracks the
// match state from the start/pause buttons and the tank/base hit events, and
// it counts the lives each player has left. It drives one-hot screen selects
// into the colorizer. Those selects only update on frame_tick, so a screen
// switch never lands in the middle of a frame.
//
// Ports:
//   clk         pixel clock, shared with the dtg and colorizer
//   reset       synchronous, active-high
//   frame_tick  one-cycle pulse at the start of vertical blanking
//   start_btn   debounced level; acts on its rising edge
//   pause_btn   debounced level; acts on its rising edge
//   tank1_hit   one-cycle pulse: tank 1 struck
//   tank2_hit   one-cycle pulse: tank 2 struck
//   base1_hit   one-cycle pulse: player-1 base destroyed
//   base2_hit   one-cycle pulse: player-2 base destroyed
//   frame1..5   screen selects: play, title, p1 win, p2 win, pause
//   game_reset  one-cycle pulse that reinitialises tanks and bullets
//   lives1/2    lives remaining per player
//
// state   | meaning
// --------+--------------------------------------------------
// S_TITLE | title screen, waiting for start
// S_PLAY  | match running, hits counted
// S_PAUSE | match frozen, hits ignored
// S_WIN1  | player 1 won, win screen held for WIN_HOLD_FRAMES
// S_WIN2  | player 2 won, win screen held for WIN_HOLD_FRAMES

module game_frame_sequencer #(
  parameter int LIVES           = 3,
  parameter int WIN_HOLD_FRAMES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       tank1_hit,
  input  logic       tank2_hit,
  input  logic       base1_hit,
  input  logic       base2_hit,
  output logic       frame1,
  output logic       frame2,
  output logic       frame3,
  output logic       frame4,
  output logic       frame5,
  output logic       game_reset,
  output logic [1:0] lives1,
  output logic [1:0] lives2
);

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAY,
    S_PAUSE,
    S_WIN1,
    S_WIN2
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [15:0] HOLD_LAST  = 16'(WIN_HOLD_FRAMES - 1);

  // Bit order {frame5, frame4, frame3, frame2, frame1}.
  localparam logic [4:0] SEL_PLAY  = 5'b00001;
  localparam logic [4:0] SEL_TITLE = 5'b00010;
  localparam logic [4:0] SEL_WIN1  = 5'b00100;
  localparam logic [4:0] SEL_WIN2  = 5'b01000;
  localparam logic [4:0] SEL_PAUSE = 5'b10000;

  state_t      state, state_nxt;
  logic [1:0]  lives1_nxt, lives2_nxt;
  logic [1:0]  lives1_dec, lives2_dec;
  logic [15:0] hold_cnt, hold_nxt;
  logic        game_reset_nxt;
  logic        start_q, pause_q;
  logic        start_e, pause_e;
  logic        fatal1, fatal2;
  logic [4:0]  frame_sel, frame_dec;

  assign start_e = start_btn & ~start_q;
  assign pause_e = pause_btn & ~pause_q;

  // Lives saturate at zero and never wrap.
  assign lives1_dec = (lives1 != 2'd0) ? lives1 - 2'd1 : 2'd0;
  assign lives2_dec = (lives2 != 2'd0) ? lives2 - 2'd1 : 2'd0;

  assign fatal1 = (tank1_hit && (lives1 == 2'd1)) || base1_hit;
  assign fatal2 = (tank2_hit && (lives2 == 2'd1)) || base2_hit;

  always_comb begin
    state_nxt      = state;
    lives1_nxt     = lives1;
    lives2_nxt     = lives2;
    hold_nxt       = '0;
    game_reset_nxt = 1'b0;
    case (state)
      S_TITLE: begin
        if (start_e) begin
          state_nxt      = S_PLAY;
          lives1_nxt     = LIVES_INIT;
          lives2_nxt     = LIVES_INIT;
          game_reset_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        if (tank1_hit) lives1_nxt = lives1_dec;
        if (tank2_hit) lives2_nxt = lives2_dec;
        // A simultaneous loss for both players is a draw, with no game_reset.
        if (fatal1 && fatal2)  state_nxt = S_TITLE;
        else if (fatal2)       state_nxt = S_WIN1;
        else if (fatal1)       state_nxt = S_WIN2;
        else if (pause_e)      state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (start_e)      state_nxt = S_TITLE;
        else if (pause_e) state_nxt = S_PLAY;
      end
      S_WIN1, S_WIN2: begin
        hold_nxt = hold_cnt;
        // The hold timeout takes precedence over a start edge in the same cycle.
        if (frame_tick && (hold_cnt == HOLD_LAST)) begin
          state_nxt = S_TITLE;
          hold_nxt  = '0;
        end else if (start_e) begin
          state_nxt      = S_PLAY;
          lives1_nxt     = LIVES_INIT;
          lives2_nxt     = LIVES_INIT;
          game_reset_nxt = 1'b1;
          hold_nxt       = '0;
        end else if (frame_tick) begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      default: state_nxt = S_TITLE;
    endcase
  end

  always_comb begin
    frame_dec = SEL_TITLE;
    case (state)
      S_PLAY:  frame_dec = SEL_PLAY;
      S_TITLE: frame_dec = SEL_TITLE;
      S_WIN1:  frame_dec = SEL_WIN1;
      S_WIN2:  frame_dec = SEL_WIN2;
      S_PAUSE: frame_dec = SEL_PAUSE;
      default: frame_dec = SEL_TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_TITLE;
      lives1     <= LIVES_INIT;
      lives2     <= LIVES_INIT;
      hold_cnt   <= '0;
      game_reset <= 1'b0;
      // Held high so a button pressed through reset does not produce an edge.
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
      frame_sel  <= SEL_TITLE;
    end else begin
      state      <= state_nxt;
      lives1     <= lives1_nxt;
      lives2     <= lives2_nxt;
      hold_cnt   <= hold_nxt;
      game_reset <= game_reset_nxt;
      start_q    <= start_btn;
      pause_q    <= pause_btn;
      // Screen selects follow the pre-edge state, and only at frame boundaries.
      if (frame_tick) frame_sel <= frame_dec;
    end
  end

  assign frame1 = frame_sel[0];
  assign frame2 = frame_sel[1];
  assign frame3 = frame_sel[2];
  assign frame4 = frame_sel[3];
  assign frame5 = frame_sel[4];

endmodule
